// File: rtl/time_base_gen.sv
// Time-of-day base: a prescaler divides CP down to one tick per second and drives
// cascaded second/minute/hour counters. The current time can be loaded and is range-checked.
module time_base_gen #(
    parameter int unsigned CLK_DIV = 100000000
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       Set_Load,
    input  logic [4:0] Set_Hour,
    input  logic [5:0] Set_Min,
    output logic       CP_Second,
    output logic       CP_Hour,
    output logic [4:0] Hour,
    output logic [4:0] Hour24,
    output logic [5:0] Minute,
    output logic [5:0] Second,
    output logic       Set_Err
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc, presc_nxt;
    logic [5:0]    sec_nxt, min_nxt;
    logic [4:0]    h24_nxt, h12_nxt;
    logic          sec_pulse_nxt, hour_pulse_nxt, err_nxt;
    logic          tc, load_ok;

    // Map a 0..23 hour onto 1..12; midnight and noon both read as 12.
    function automatic logic [4:0] to_12h(input logic [4:0] h);
        if (h == 5'd0 || h == 5'd12) begin
            return 5'd12;
        end else if (h > 5'd12) begin
            return 5'(h - 5'd12);
        end else begin
            return h;
        end
    endfunction

    assign tc      = (presc == PRESC_TC);
    assign load_ok = (Set_Hour <= 5'd23) && (Set_Min <= 6'd59);

    // Next-state: an accepted load wins over the tick; a rejected load lets the tick proceed.
    always_comb begin
        presc_nxt      = presc;
        sec_nxt        = Second;
        min_nxt        = Minute;
        h24_nxt        = Hour24;
        sec_pulse_nxt  = 1'b0;
        hour_pulse_nxt = 1'b0;
        err_nxt        = Set_Load && !load_ok;

        if (Set_Load && load_ok) begin
            presc_nxt = '0;
            sec_nxt   = 6'd0;
            min_nxt   = Set_Min;
            h24_nxt   = Set_Hour;
        end else if (tc) begin
            presc_nxt     = '0;
            sec_pulse_nxt = 1'b1;
            if (Second == 6'd59) begin
                sec_nxt = 6'd0;
                if (Minute == 6'd59) begin
                    min_nxt        = 6'd0;
                    hour_pulse_nxt = 1'b1;
                    h24_nxt        = (Hour24 == 5'd23) ? 5'd0 : 5'(Hour24 + 5'd1);
                end else begin
                    min_nxt = 6'(Minute + 6'd1);
                end
            end else begin
                sec_nxt = 6'(Second + 6'd1);
            end
        end else begin
            presc_nxt = PW'(presc + PW'(1));
        end

        h12_nxt = to_12h(h24_nxt);
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            presc     <= '0;
            Second    <= 6'd0;
            Minute    <= 6'd0;
            Hour24    <= 5'd0;
            Hour      <= 5'd12;
            CP_Second <= 1'b0;
            CP_Hour   <= 1'b0;
            Set_Err   <= 1'b0;
        end else begin
            presc     <= presc_nxt;
            Second    <= sec_nxt;
            Minute    <= min_nxt;
            Hour24    <= h24_nxt;
            Hour      <= h12_nxt;
            CP_Second <= sec_pulse_nxt;
            CP_Hour   <= hour_pulse_nxt;
            Set_Err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_time_base_gen.sv
// Bench for time_base_gen at CLK_DIV=4: a seconds-of-day reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_time_base_gen;

    localparam int DIV = 4;

    logic       CP = 1'b0;
    logic       CR = 1'b1;
    logic       Set_Load = 1'b0;
    logic [4:0] Set_Hour = 5'd0;
    logic [5:0] Set_Min = 6'd0;
    logic       CP_Second, CP_Hour, Set_Err;
    logic [4:0] Hour, Hour24;
    logic [5:0] Minute, Second;

    int checks = 0;
    int failures = 0;
    int hour_pulses = 0;

    // Reference state: time of day in seconds, and cycles elapsed within the current second.
    int m_tod = 0;
    int m_phase = 0;
    bit m_sec_p = 0;
    bit m_hour_p = 0;
    bit m_err = 0;
    bit m_valid = 0;

    time_base_gen #(.CLK_DIV(DIV)) dut (
        .CP(CP), .CR(CR), .Set_Load(Set_Load), .Set_Hour(Set_Hour), .Set_Min(Set_Min),
        .CP_Second(CP_Second), .CP_Hour(CP_Hour), .Hour(Hour), .Hour24(Hour24),
        .Minute(Minute), .Second(Second), .Set_Err(Set_Err)
    );

    always #5 CP = ~CP;

    always @(posedge CP) begin
        bit legal;
        int t;
        legal = (int'(Set_Hour) <= 23) && (int'(Set_Min) <= 59);
        t = (m_tod + 1) % 86400;
        if (CR) begin
            m_tod <= 0; m_phase <= 0; m_sec_p <= 0; m_hour_p <= 0; m_err <= 0; m_valid <= 1;
        end else begin
            m_err <= Set_Load && !legal;
            if (Set_Load && legal) begin
                m_tod <= int'(Set_Hour) * 3600 + int'(Set_Min) * 60;
                m_phase <= 0; m_sec_p <= 0; m_hour_p <= 0;
            end else if (m_phase == DIV - 1) begin
                m_tod <= t; m_phase <= 0; m_sec_p <= 1; m_hour_p <= (t % 3600 == 0);
            end else begin
                m_phase <= m_phase + 1; m_sec_p <= 0; m_hour_p <= 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the reference model.
    always @(negedge CP) begin
        int eh, eh12;
        if (m_valid) begin
            eh = m_tod / 3600;
            eh12 = (eh % 12 == 0) ? 12 : eh % 12;
            chk("model.Hour24", int'(Hour24), eh);
            chk("model.Hour", int'(Hour), eh12);
            chk("model.Minute", int'(Minute), (m_tod / 60) % 60);
            chk("model.Second", int'(Second), m_tod % 60);
            chk("model.CP_Second", int'(CP_Second), int'(m_sec_p));
            chk("model.CP_Hour", int'(CP_Hour), int'(m_hour_p));
            chk("model.Set_Err", int'(Set_Err), int'(m_err));
            if (CP_Hour) hour_pulses++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CP);
    endtask

    task automatic load(input int h, input int m);
        Set_Load = 1'b1; Set_Hour = 5'(h); Set_Min = 6'(m);
        cyc(1);
        Set_Load = 1'b0;
    endtask

    initial begin
        int h0;
        // Reset held two cycles, then released.
        CR = 1'b1;
        cyc(2);
        CR = 1'b0;
        chk("rst.Hour24", int'(Hour24), 0);
        chk("rst.Hour", int'(Hour), 12);
        chk("rst.Minute", int'(Minute), 0);
        chk("rst.Second", int'(Second), 0);
        cyc(3);
        chk("rst.no_early_tick", int'(CP_Second), 0);
        cyc(1);
        chk("rst.first_tick", int'(CP_Second), 1);
        chk("rst.first_second", int'(Second), 1);
        cyc(4);
        chk("rst.second_tick", int'(CP_Second), 1);

        // Hour rollover 05:59 -> 06:00.
        load(5, 59);
        chk("h.load_no_pulse", int'(CP_Second), 0);
        chk("h.load_min", int'(Minute), 59);
        h0 = hour_pulses;
        cyc(240);
        chk("h.cp_hour", int'(CP_Hour), 1);
        chk("h.cp_second", int'(CP_Second), 1);
        chk("h.Hour24", int'(Hour24), 6);
        chk("h.Hour", int'(Hour), 6);
        chk("h.Minute", int'(Minute), 0);
        cyc(1);
        chk("h.single_pulse", hour_pulses - h0, 1);

        // Day wrap 23:59:59 -> 00:00:00, then 13:00 reads as 1.
        load(23, 59);
        cyc(240);
        chk("d.cp_hour", int'(CP_Hour), 1);
        chk("d.Hour24", int'(Hour24), 0);
        chk("d.Hour", int'(Hour), 12);
        load(13, 0);
        chk("d.Hour13", int'(Hour), 1);

        // Illegal loads: error pulse, time and cadence untouched.
        load(24, 0);
        chk("i.err_hour", int'(Set_Err), 1);
        chk("i.Hour24", int'(Hour24), 13);
        load(5, 60);
        chk("i.err_min", int'(Set_Err), 1);
        chk("i.Minute", int'(Minute), 0);
        cyc(1);
        chk("i.err_clear", int'(Set_Err), 0);
        cyc(1);
        chk("i.cadence", int'(CP_Second), 1);
        cyc(3);
        load(31, 0);
        chk("i.tc_err", int'(Set_Err), 1);
        chk("i.tc_tick", int'(CP_Second), 1);
        chk("i.tc_second", int'(Second), 2);

        // Accepted load on a TC cycle suppresses the tick.
        cyc(3);
        load(7, 0);
        chk("s.Hour24", int'(Hour24), 7);
        chk("s.Second", int'(Second), 0);
        chk("s.no_tick", int'(CP_Second), 0);
        chk("s.no_hour", int'(CP_Hour), 0);
        cyc(3);
        chk("s.no_early", int'(CP_Second), 0);
        cyc(1);
        chk("s.next_tick", int'(CP_Second), 1);

        // Reset at 12:34:56 with prescaler at 2, overriding a concurrent load.
        load(12, 34);
        cyc(224);
        chk("r.pre_second", int'(Second), 56);
        cyc(2);
        CR = 1'b1; Set_Load = 1'b1; Set_Hour = 5'd3; Set_Min = 6'd3;
        cyc(1);
        CR = 1'b0; Set_Load = 1'b0;
        chk("r.Hour24", int'(Hour24), 0);
        chk("r.Hour", int'(Hour), 12);
        chk("r.Minute", int'(Minute), 0);
        chk("r.Second", int'(Second), 0);
        chk("r.CP_Second", int'(CP_Second), 0);
        cyc(3);
        chk("r.no_stale", int'(CP_Second), 0);
        cyc(1);
        chk("r.first_tick", int'(CP_Second), 1);

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_base_gen.md
TIME_BASE_GEN -- requirements
Module: time_base_gen

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 100000000, giving the number of CP cycles per second (legal range 2..2^27).
REQ-002 The module SHALL have port CP, input, 1 bit: system clock; all state SHALL update on its rising edge only.
REQ-003 The module SHALL have port CR, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port Set_Load, input, 1 bit: single-cycle time-set request.
REQ-005 The module SHALL have port Set_Hour, input, 5 bits: hour to load, binary 0..23.
REQ-006 The module SHALL have port Set_Min, input, 6 bits: minute to load, binary 0..59.
REQ-007 The module SHALL have port CP_Second, output, 1 bit: one-CP-cycle pulse per elapsed second.
REQ-008 The module SHALL have port CP_Hour, output, 1 bit: one-CP-cycle pulse at each hour rollover.
REQ-009 The module SHALL have port Hour, output, 5 bits: chime hour in 12-hour form, 1..12.
REQ-010 The module SHALL have port Hour24, output, 5 bits: current hour, binary 0..23.
REQ-011 The module SHALL have port Minute, output, 6 bits: current minute, binary 0..59.
REQ-012 The module SHALL have port Second, output, 6 bits: current second, binary 0..59.
REQ-013 The module SHALL have port Set_Err, output, 1 bit: one-cycle pulse when a Set_Load is rejected.

Function
REQ-014 The prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; terminal count (TC) is the cycle in which it equals CLK_DIV-1.
REQ-015 On a TC edge, Second SHALL increment; 59 SHALL wrap to 0 and carry into Minute.
REQ-016 On a minute carry, Minute SHALL increment; 59 SHALL wrap to 0 and carry into Hour24.
REQ-017 On an hour carry, Hour24 SHALL increment; 23 SHALL wrap to 0.
REQ-018 CP_Second SHALL be registered and high for exactly the one cycle following each TC edge, aligned with the updated Second.
REQ-019 CP_Hour SHALL be registered and high for exactly the one cycle following an hour carry, coincident with CP_Second, with Hour and Hour24 already showing the new value.
REQ-020 Hour SHALL equal Hour24 mod 12, except that it SHALL be 12 when Hour24 mod 12 is 0; Hour SHALL never be 0, so a chime consumer computing Hour-1 never underflows.
REQ-021 Set_Load SHALL be sampled on every edge; an accepted load requires Set_Hour<=23 and Set_Min<=59.
REQ-022 An accepted load SHALL write Hour24=Set_Hour and Minute=Set_Min, and clear Second and the prescaler to 0 on the same edge.
REQ-023 An accepted load SHALL NOT generate CP_Second or CP_Hour, including a load that sets minute 0.
REQ-024 A rejected load SHALL leave all counters unchanged, let timekeeping continue normally, and pulse Set_Err for one cycle.
REQ-025 When Set_Load coincides with TC, an accepted load SHALL take priority: the tick is discarded and no pulse is emitted.
REQ-026 When Set_Load coincides with TC and the load is rejected, the tick SHALL proceed normally and Set_Err SHALL pulse in the same cycle as CP_Second.
REQ-027 The full rollover 23:59:59 -> 00:00:00 SHALL produce CP_Second=1, CP_Hour=1, Hour24=0 and Hour=12.

Reset
REQ-028 When CR=1 on an edge, the prescaler, Second, Minute and Hour24 SHALL be set to 0.
REQ-029 When CR=1 on an edge, CP_Second, CP_Hour and Set_Err SHALL be set to 0, and Hour SHALL be 12.
REQ-030 CR SHALL override Set_Load and TC in the same cycle; a reset mid-second SHALL discard the partial prescaler count.
REQ-031 After CR is released, the first CP_Second SHALL occur exactly CLK_DIV cycles later.

Verification (CLK_DIV=4)
REQ-032 Reset check: hold CR for 2 cycles, then release. Required response: Hour24=0, Hour=12, Minute=0, Second=0, and CP_Second pulses 4 cycles after release and every 4 cycles thereafter.
REQ-033 Hour rollover: load 05:59, then run 60 seconds (240 cycles). Required response: a single CP_Hour pulse coincident with CP_Second, Hour24=6, Hour=6, Minute=0.
REQ-034 Day wrap: load 23:59, then run 60 seconds. Required response: CP_Hour=1, Hour24=0, Hour=12; 13:00 SHALL read as Hour=1.
REQ-035 Illegal load: Set_Load with Set_Hour=24, then with Set_Min=60. Required response: each produces a Set_Err pulse, the time is unchanged, and the tick cadence is unbroken.
REQ-036 Simultaneous events: Set_Load 07:00 on a TC cycle. Required response: Hour24=7, Minute=0, Second=0, and no CP_Second or CP_Hour that cycle; the next CP_Second comes 4 cycles later.
REQ-037 Mid-operation reset: assert CR while the prescaler is at 2 and time is 12:34:56. Required response: all outputs match their reset values next cycle, and no stale pulse appears.
